serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 10 +
 rtl/serial_adder_ctrl_if.sv | 16 +
 rtl/serial_adder_ctrl_fa.sv | 18 +
 rtl/serial_adder_ctrl.sv | 94 +++++++++
 tb/tb_serial_adder_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl; WIDTH must match the attached adder.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder built from two half-adder stages.
module full_adder_using_ha (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic s1, c1, c2;

    always_comb begin
        s1   = a ^ b;
        c1   = a & b;
        sum  = s1 ^ cin;
        c2   = s1 & cin;
        cout = c1 | c2;
    end
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell fed LSB first, registered carry between slices.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               fa_s, fa_cout;

    full_adder_using_ha u_fa (
        .sum  (fa_s),
        .cout (fa_cout),
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last slice: publish the result on the same edge that enters DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = sum_sr_d;
                    cout_d  = fa_cout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int checks   = 0;
    int failures = 0;

    // Result each adder should be presenting; pending values load when done is seen.
    logic [8:0] pend8 = '0, exp8 = '0;
    logic [4:0] pend4 = '0, exp4 = '0;
    bit         mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus8.done) exp8 = pend8;
            if (bus4.done) exp4 = pend4;
            check("hold8", 64'({bus8.cout, bus8.sum}), 64'(exp8));
            check("hold4", 64'({bus4.cout, bus4.sum}), 64'(exp4));
        end
    end

    task automatic fire(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input bit keep);
        @(negedge clk);
        if (w == 8) begin
            bus8.start = 1'b1; bus8.a = av; bus8.b = bv; bus8.cin = ci;
            pend8 = 9'(av) + 9'(bv) + 9'(ci);
        end else begin
            bus4.start = 1'b1; bus4.a = av[3:0]; bus4.b = bv[3:0]; bus4.cin = ci;
            pend4 = 5'(av[3:0]) + 5'(bv[3:0]) + 5'(ci);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            bus8.start = 1'b0;
            bus4.start = 1'b0;
        end
    endtask

    task automatic wait_done(input int w, output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        repeat (w + 6) begin
            @(negedge clk);
            lat++;
            if ((w == 8) ? bus8.busy : bus4.busy) busy_n++;
            if ((w == 8) ? bus8.done : bus4.done) return;
        end
        lat = -1;
    endtask

    task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input string tag);
        int lat, bn;
        logic [63:0] e, got;
        fire(w, av, bv, ci, 1'b0);
        wait_done(w, lat, bn);
        if (w == 8) e = 64'(av) + 64'(bv) + 64'(ci);
        else        e = 64'(av[3:0]) + 64'(bv[3:0]) + 64'(ci);
        got = (w == 8) ? 64'({bus8.cout, bus8.sum}) : 64'({bus4.cout, bus4.sum});
        check({tag, "_lat"}, 64'(lat), 64'(w + 1));
        check({tag, "_busy"}, 64'(bn), 64'(w));
        check({tag, "_res"}, got, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy8", 64'(bus8.busy), 64'd0);
        check("rst_done8", 64'(bus8.done), 64'd0);
        check("rst_res8", 64'({bus8.cout, bus8.sum}), 64'd0);
        check("rst_busy4", 64'(bus4.busy), 64'd0);
        check("rst_res4", 64'({bus4.cout, bus4.sum}), 64'd0);

        op(8, 8'hA5, 8'h3C, 1'b0, "a5_3c");
        check("a5_3c_const", 64'({bus8.cout, bus8.sum}), 64'h0E1);
        op(8, 8'hFF, 8'h01, 1'b0, "ripple1");
        check("ripple1_const", 64'({bus8.cout, bus8.sum}), 64'h100);
        op(8, 8'hFF, 8'h00, 1'b1, "ripple2");
        check("ripple2_const", 64'({bus8.cout, bus8.sum}), 64'h100);

        // start held high; operands scrambled after acceptance
        fire(8, 8'h10, 8'h20, 1'b0, 1'b1);
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'b1;
        wait_done(8, lat, bn);
        check("held1_lat", 64'(lat), 64'd9);
        check("held1_busy", 64'(bn), 64'd8);
        check("held1_res", 64'({bus8.cout, bus8.sum}), 64'h030);
        @(negedge clk);
        bus8.a = 8'h05; bus8.b = 8'h07; bus8.cin = 1'b0; pend8 = 9'h00C;
        check("held_idle_done", 64'(bus8.done), 64'd0);
        wait_done(8, lat, bn);
        bus8.start = 1'b0;
        check("held2_lat", 64'(lat), 64'd9);
        check("held2_res", 64'({bus8.cout, bus8.sum}), 64'h00C);

        // reset during SHIFT aborts the add
        fire(8, 8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_busy_pre", 64'(bus8.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp8 = '0; exp4 = '0;
        @(negedge clk);
        check("abort_busy", 64'(bus8.busy), 64'd0);
        check("abort_done", 64'(bus8.done), 64'd0);
        check("abort_res", 64'({bus8.cout, bus8.sum}), 64'd0);
        wait_done(8, lat, bn);
        check("abort_nodone", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        check("abort_nobusy", 64'(bn), 64'd0);
        op(8, 8'h01, 8'h01, 1'b0, "post_abort");
        check("post_abort_const", 64'({bus8.cout, bus8.sum}), 64'h002);

        op(4, 8'h0F, 8'h00, 1'b1, "w4_ripple");
        check("w4_ripple_const", 64'({bus4.cout, bus4.sum}), 64'h10);

        for (int i = 0; i < 1000; i++)
            op(8, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand8");
        for (int i = 0; i < 1000; i++)
            op(4, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand4");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
